// File: rtl/quiz_lockout_arbiter.sv
// First-press-wins quiz arbiter: host arm, lockout, per-answer countdown and bell tone code.
// Optional early-press foul detection is built when QUIZ_FOUL_DETECT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for host start
// ARMED   | armed, first press wins
// LOCKED  | winner latched, countdown running
// TIMEOUT | countdown expired, hold until clear
// FOUL    | early press in IDLE, hold until clear
module quiz_lockout_arbiter #(
  parameter int N_PLAYERS  = 8,
  parameter int ID_W       = 3,
  parameter int TICK_DIV   = 50000000,
  parameter int ANSWER_SEC = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [N_PLAYERS-1:0] key_n,
  output logic [2:0]           state,
  output logic                 winner_valid,
  output logic [ID_W-1:0]      winner_id,
  output logic                 foul_valid,
  output logic [ID_W-1:0]      foul_id,
  output logic [7:0]           countdown,
  output logic [2:0]           bell_code
);

  localparam int TICK_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_LOCKED  = 3'd2,
    S_TIMEOUT = 3'd3,
    S_FOUL    = 3'd4
  } state_t;

  state_t                st;
  logic [N_PLAYERS-1:0]  sync1, sync2, sync3, press;
  logic [TICK_W-1:0]     tick_cnt;
  logic [ID_W-1:0]       press_id;

  // Buttons are active-low; a press is a registered 1->0 transition after the synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      sync3 <= '1;
      press <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync3 & ~sync2;
    end
  end

  function automatic logic [ID_W-1:0] lowest_idx(input logic [N_PLAYERS-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--)
      if (v[i]) idx = ID_W'(i);
    return idx;
  endfunction

  assign press_id = lowest_idx(press);
  assign state    = st;

`ifdef QUIZ_FOUL_DETECT_EN
  logic            foul_valid_r;
  logic [ID_W-1:0] foul_id_r;
  assign foul_valid = foul_valid_r;
  assign foul_id    = foul_id_r;
`else
  assign foul_valid = 1'b0;
  assign foul_id    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_IDLE;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      countdown    <= '0;
      bell_code    <= '0;
      tick_cnt     <= '0;
`ifdef QUIZ_FOUL_DETECT_EN
      foul_valid_r <= 1'b0;
      foul_id_r    <= '0;
`endif
    end else if (clear) begin
      st           <= S_IDLE;
      winner_valid <= 1'b0;
      countdown    <= '0;
      bell_code    <= '0;
`ifdef QUIZ_FOUL_DETECT_EN
      foul_valid_r <= 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (start) begin
            st <= S_ARMED;
`ifdef QUIZ_FOUL_DETECT_EN
          end else if (|press) begin
            st           <= S_FOUL;
            foul_valid_r <= 1'b1;
            foul_id_r    <= press_id;
            bell_code    <= 3'd5;
`endif
          end
        end
        S_ARMED: begin
          if (|press) begin
            st           <= S_LOCKED;
            winner_valid <= 1'b1;
            winner_id    <= press_id;
            countdown    <= 8'(ANSWER_SEC);
            tick_cnt     <= '0;
            bell_code    <= 3'd1;
          end
        end
        S_LOCKED: begin
          if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            // Win chime lasts only until the first tick wrap.
            if (countdown <= 8'd1) begin
              st        <= S_TIMEOUT;
              countdown <= '0;
              bell_code <= 3'd7;
            end else begin
              countdown <= countdown - 8'd1;
              bell_code <= 3'd0;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        S_TIMEOUT: ;
`ifdef QUIZ_FOUL_DETECT_EN
        S_FOUL: ;
`endif
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_lockout_arbiter.sv
// Directed scoreboard bench for quiz_lockout_arbiter (N_PLAYERS=8, TICK_DIV=10, ANSWER_SEC=3).
module tb_quiz_lockout_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic [7:0] key_n;
  logic [2:0] state;
  logic       winner_valid;
  logic [2:0] winner_id;
  logic       foul_valid;
  logic [2:0] foul_id;
  logic [7:0] countdown;
  logic [2:0] bell_code;

  int n_cmp = 0;
  int n_err = 0;

  logic [21:0] exp_q[$];
  string       tag_q[$];
  logic [2:0]  wid_e = 3'd0;
  logic [2:0]  fid_e = 3'd0;

  quiz_lockout_arbiter #(
    .N_PLAYERS(8), .ID_W(3), .TICK_DIV(10), .ANSWER_SEC(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .key_n(key_n),
    .state(state), .winner_valid(winner_valid), .winner_id(winner_id),
    .foul_valid(foul_valid), .foul_id(foul_id), .countdown(countdown),
    .bell_code(bell_code)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [2:0] s, input logic wv,
                      input logic [2:0] wid, input logic fv, input logic [2:0] fid,
                      input logic [7:0] cd, input logic [2:0] b);
    exp_q.push_back({s, wv, wid, fv, fid, cd, b});
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [21:0] obs, exp_v;
    string tag;
    obs = {state, winner_valid, winner_id, foul_valid, foul_id, countdown, bell_code};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      return;
    end
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed st=%0d wv=%0b wid=%0d fv=%0b fid=%0d cd=%0d bell=%0d, expected st=%0d wv=%0b wid=%0d fv=%0b fid=%0d cd=%0d bell=%0d",
             tag, obs[21:19], obs[18], obs[17:15], obs[14], obs[13:11], obs[10:3], obs[2:0],
             exp_v[21:19], exp_v[18], exp_v[17:15], exp_v[14], exp_v[13:11], exp_v[10:3], exp_v[2:0]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; key_n = 8'hFF;
    #23;
    push("reset", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 3'd0);
    check_pop();
    cyc(1); rst = 1'b0; cyc(2);

    // Arm and win with player 5, then run out the countdown.
    push("armed1", 3'd1, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_start(); check_pop();
    key_n[5] = 1'b0;
    push("pre_lock", 3'd1, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    cyc(3); check_pop();
    wid_e = 3'd5;
    push("lock5", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd3, 3'd1);
    cyc(1); check_pop();
    key_n[5] = 1'b1;
    push("chime_end", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd3, 3'd1);
    cyc(9); check_pop();
    push("cd2", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd2, 3'd0);
    cyc(1); check_pop();
    push("cd1", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd1, 3'd0);
    cyc(19); check_pop();
    push("timeout5", 3'd3, 1'b1, wid_e, 1'b0, fid_e, 8'd0, 3'd7);
    cyc(1); check_pop();
    push("clear1", 3'd0, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_clear(); check_pop();

    // Tie between 6 and 2, later press on 0 is locked out.
    push("armed2", 3'd1, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_start(); check_pop();
    key_n[6] = 1'b0; key_n[2] = 1'b0;
    wid_e = 3'd2;
    push("tie_lock2", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd3, 3'd1);
    cyc(4); check_pop();
    key_n = 8'hFF; key_n[0] = 1'b0;
    push("lockout_cd3", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd3, 3'd1);
    cyc(5); check_pop();
    push("lockout_cd2", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd2, 3'd0);
    cyc(5); check_pop();
    push("lockout_cd1", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd1, 3'd0);
    cyc(10); check_pop();
    push("lockout_cd0", 3'd3, 1'b1, wid_e, 1'b0, fid_e, 8'd0, 3'd7);
    cyc(10); check_pop();
    key_n = 8'hFF;
    push("clear2", 3'd0, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_clear(); check_pop();

    // Key 4 held through arming (start lands on the press edge so no foul either way).
    key_n[4] = 1'b0;
    cyc(3);
    push("held_armed", 3'd1, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_start(); check_pop();
    push("held_no_win", 3'd1, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    cyc(20); check_pop();
    key_n[4] = 1'b1; cyc(5); key_n[4] = 1'b0;
    wid_e = 3'd4;
    push("repress_lock4", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd3, 3'd1);
    cyc(4); check_pop();
    push("clear_locked", 3'd0, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_clear(); check_pop();
    key_n = 8'hFF; cyc(3);

    // Early press in IDLE.
    key_n[3] = 1'b0;
`ifdef QUIZ_FOUL_DETECT_EN
    fid_e = 3'd3;
    push("foul3", 3'd4, 1'b0, wid_e, 1'b1, fid_e, 8'd0, 3'd5);
    cyc(4); check_pop();
    push("foul_start_ign", 3'd4, 1'b0, wid_e, 1'b1, fid_e, 8'd0, 3'd5);
    pulse_start(); check_pop();
    push("foul_clear", 3'd0, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_clear(); check_pop();
    key_n = 8'hFF; cyc(3);
`else
    push("idle_press_ign", 3'd0, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    cyc(4); check_pop();
    key_n = 8'hFF; cyc(3);
    push("armed_nofoul", 3'd1, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_start(); check_pop();
    key_n[1] = 1'b0;
    wid_e = 3'd1;
    push("lock1", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd3, 3'd1);
    cyc(4); check_pop();
    push("clear_nofoul", 3'd0, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_clear(); check_pop();
    key_n = 8'hFF; cyc(3);
`endif

    // clear on the same edge as the winning press.
    push("armed3", 3'd1, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_start(); check_pop();
    key_n[7] = 1'b0;
    cyc(3);
    push("clear_beats_press", 3'd0, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_clear(); check_pop();
    push("clear_stays_idle", 3'd0, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    cyc(3); check_pop();
    key_n = 8'hFF; cyc(3);

    // Asynchronous reset in the middle of LOCKED.
    push("armed4", 3'd1, 1'b0, wid_e, 1'b0, fid_e, 8'd0, 3'd0);
    pulse_start(); check_pop();
    key_n[0] = 1'b0;
    wid_e = 3'd0;
    push("lock0", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd3, 3'd1);
    cyc(4); check_pop();
    push("lock0_cd2", 3'd2, 1'b1, wid_e, 1'b0, fid_e, 8'd2, 3'd0);
    cyc(10); check_pop();
    #2 rst = 1'b1; key_n = 8'hFF;
    fid_e = 3'd0;
    push("async_reset", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 3'd0);
    #1 check_pop();
    cyc(2); rst = 1'b0;
    push("post_reset", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 3'd0);
    cyc(3); check_pop();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/quiz_lockout_arbiter.md
Name: quiz_lockout_arbiter

Overview:
Parametrised N-player answer arbiter. It replaces the fixed 7-button selecting machine with a host-armed, first-press-wins lockout, a per-answer countdown, and a 3-bit tone code. The tone code feeds the existing bell tone generator. Winner ID and countdown feed the existing segment/lattice display decoders.

Parameters:
N_PLAYERS, 8, number of player buttons (2..8)
ID_W, 3, width of winner/foul ID (ceil(log2(N_PLAYERS)), min 1)
TICK_DIV, 50000000, clk cycles per countdown tick (1 s at 50 MHz), >=2
ANSWER_SEC, 10, countdown load value in ticks, 1..255

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-high reset
start  input  1  host arm pulse, synchronous, pre-debounced
clear  input  1  host return-to-idle pulse, synchronous, pre-debounced
key_n  input  N_PLAYERS  raw player buttons, active-low, asynchronous
state  output  3  0=IDLE 1=ARMED 2=LOCKED 3=TIMEOUT 4=FOUL
winner_valid  output  1  high while LOCKED or TIMEOUT
winner_id  output  ID_W  index of winning player
foul_valid  output  1  high while FOUL
foul_id  output  ID_W  index of early presser
countdown  output  8  remaining ticks, binary
bell_code  output  3  tone select for bell block (0=silent)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. All registers reset asynchronously.
- Reset values: state=IDLE, winner_valid=0, winner_id=0, foul_valid=0, foul_id=0, countdown=0, bell_code=0. Sync flops reset to all-1 (released).
- Input path: key_n passes a 2-FF synchronizer, then a registered falling-edge detect. press[i] is a 1-cycle pulse per press.
  - Only edges count. A button held down across arming never wins.
- Latency: key_n[i] first sampled low at edge k gives press[i] high during cycle k+2. State and outputs update at edge k+3.
- Priority within one cycle: clear > start > press.
- Tie rule: several press bits in one cycle → lowest index wins.
- IDLE:
  - start → ARMED.
  - press → FOUL, foul_id = lowest pressed index (only with the optional feature; otherwise ignored).
- ARMED:
  - press → LOCKED; winner_id = lowest pressed index.
  - countdown loads ANSWER_SEC; tick counter restarts at 0.
  - start ignored.
- LOCKED:
  - Tick counter counts 0..TICK_DIV-1 and wraps. On wrap, countdown decrements.
  - When countdown would decrement from 1 to 0 → TIMEOUT with countdown=0.
  - All presses and start ignored.
- TIMEOUT: holds until clear. winner_id is retained.
- FOUL: holds until clear. Presses ignored.
- clear (any state): → IDLE next edge. winner_valid=0, foul_valid=0, countdown=0, bell_code=0. winner_id and foul_id retain their last values.
- clear on the same edge as a winning press: clear wins; no lock occurs.
- bell_code is registered and derived from state:
  - LOCKED, first tick after lock: 1 (win chime).
  - LOCKED, rest of the countdown: 0.
  - TIMEOUT: 7.
  - FOUL: 5.
  - IDLE and ARMED: 0.
- Tick counter width: ceil(log2(TICK_DIV)) bits. Countdown never underflows.
- Unused key_n bits beyond N_PLAYERS do not exist; the width is exactly N_PLAYERS.

Optional Feature:
QUIZ_FOUL_DETECT_EN
- Defined:
  - press in IDLE → FOUL, foul_valid=1, foul_id=lowest pressed index, bell_code=5.
  - Exit only via clear.
- Undefined:
  - Presses in IDLE are ignored. The FOUL state and the foul registers are not built.
  - foul_valid is tied 0 and foul_id is tied 0. The state encoding 4 never occurs.

Test Plan:
- Bench parameters: N_PLAYERS=8, TICK_DIV=10, ANSWER_SEC=3.
- Arm and win: rst, start, key_n[5] low at edge k → edge k+3: state=2, winner_valid=1, winner_id=5, countdown=3, bell_code=1. After 30 cycles: state=3, countdown=0, bell_code=7.
- Tie and lockout: start, then key_n[6] and key_n[2] low on the same edge → winner_id=2. A later key_n[0] press leaves winner_id=2. Countdown reads 3,2,1,0 at 10-cycle spacing.
- Held key: key_n[4] held low through start, no other press → state stays 1. Release then re-press key_n[4] → winner_id=4.
- Foul (macro defined): key_n[3] pressed in IDLE → state=4, foul_valid=1, foul_id=3, bell_code=5. start ignored. clear → state=0, foul_valid=0.
- Foul (macro undefined): the same press leaves state=0, and a following start/press arms and locks normally.
- Clear precedence and async reset: clear coincident with the winning press edge → state=0, winner_valid=0. rst asserted mid-LOCKED (countdown=2) → all outputs at reset values immediately, without a clk edge.
